// File: rtl/crc_stream_engine.sv
// ============================================================================
// crc_stream_engine : frame-aware Galois CRC generator/checker, LSB-first.
// Optional error counter: define CRC_STREAM_ERRCNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module crc_stream_engine #(
   parameter int               DATA_W = 32,
   parameter int               CRC_W  = 20,
   parameter logic [CRC_W-1:0] POLY   = 20'hC1ACF,
   parameter logic [CRC_W-1:0] INIT   = '1,
   parameter logic [CRC_W-1:0] XOROUT = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   input  logic [DATA_W-1:0]   s_data,
   input  logic                s_sof,
   input  logic                s_eof,
   input  logic [DATA_W/8-1:0] s_keep,
   input  logic                chk_en,
   input  logic [CRC_W-1:0]    chk_crc,
   output logic [CRC_W-1:0]    crc_out,
   output logic                crc_valid,
   output logic                crc_err,
   output logic                orphan,
   output logic                busy
`ifdef CRC_STREAM_ERRCNT_EN
   ,
   input  logic                err_cnt_clr,
   output logic [15:0]         err_cnt
`endif
);

   localparam int NB = DATA_W / 8;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   logic [0:0]       r_state;
   logic [CRC_W-1:0] r_crc;
   logic [NB-1:0]    w_byte_en;
   logic [CRC_W-1:0] w_next;
   logic [CRC_W-1:0] w_result;
   logic             w_accept;

   // Only the contiguous run of kept bytes starting at byte 0 counts on eof.
   always_comb begin : g_byte_en
      logic run;
      run       = 1'b1;
      w_byte_en = '0;
      for (int i = 0; i < NB; i++) begin
         run          = run & (~s_eof | s_keep[i]);
         w_byte_en[i] = run;
      end
   end

   always_comb begin : g_lfsr
      logic fb;
      fb     = 1'b0;
      w_next = s_sof ? INIT : r_crc;
      for (int i = 0; i < DATA_W; i++) begin
         if (w_byte_en[i/8]) begin
            fb     = w_next[CRC_W-1] ^ s_data[i];
            w_next = {w_next[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
         end
      end
   end

   assign w_result = w_next ^ XOROUT;
   assign w_accept = s_valid & (s_sof | (r_state == ST_ACTIVE));
   assign busy     = (r_state == ST_ACTIVE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_crc     <= INIT;
         crc_out   <= INIT ^ XOROUT;
         crc_valid <= 1'b0;
         crc_err   <= 1'b0;
         orphan    <= 1'b0;
      end else begin
         crc_valid <= 1'b0;
         if (w_accept) begin
            r_crc <= w_next;
            if (s_eof) begin
               r_state   <= ST_IDLE;
               crc_valid <= 1'b1;
               crc_out   <= w_result;
               crc_err   <= chk_en & (w_result != chk_crc);
            end else begin
               r_state <= ST_ACTIVE;
            end
         end else if (s_valid) begin
            orphan <= 1'b1;
         end
      end
   end

`ifdef CRC_STREAM_ERRCNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 16'h0000;
      end else if (err_cnt_clr) begin
         err_cnt <= 16'h0000;
      end else if (crc_valid && crc_err && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'h0001;
      end
   end
`endif

endmodule

`default_nettype wire
